// File: rtl/reg_read_stage.sv
// Operand-read stage: NUM_REGS x DATA_W register file with one write port,
// two combinational read ports with same-cycle write-through bypass, and the
// ID/EX pipeline register that carries both operands toward execute.
// The ID/EX register supports flush (bubble), stall (hold with writeback
// refresh so held operands never go stale) and normal load.
module reg_read_stage #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int R0_ZERO  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              stall,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr_a,
    output logic [ADDR_W-1:0] out_addr_b,
    output logic [DATA_W-1:0] out_data_a,
    output logic [DATA_W-1:0] out_data_b
);

    // True when addr names the hard-wired zero register of an R0_ZERO build.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (R0_ZERO != 0) && (addr == '0);
    endfunction

    // True when this cycle's writeback actually lands in register addr.
    function automatic logic write_hits(
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [ADDR_W-1:0] addr
    );
        return we && (waddr == addr) && !is_zero_reg(addr);
    endfunction

    // Architectural read value: zero register, then bypass, then storage.
    function automatic logic [DATA_W-1:0] read_value(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (is_zero_reg(addr)) begin
            return '0;
        end else if (write_hits(we, waddr, addr)) begin
            return wdata;
        end else begin
            return stored;
        end
    endfunction

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [DATA_W-1:0] rv_a_p0;
    logic [DATA_W-1:0] rv_b_p0;
    logic              hit_a_p1;
    logic              hit_b_p1;

    logic              vld_p1;
    logic [ADDR_W-1:0] addr_a_p1;
    logic [ADDR_W-1:0] addr_b_p1;
    logic [DATA_W-1:0] data_a_p1;
    logic [DATA_W-1:0] data_b_p1;

    // Register file storage: single write port, writes never blocked by stall/flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && !is_zero_reg(wr_addr)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // ---- stage p0: decode-side read ports with write-through bypass ----
    // Read ports A and B, evaluated independently, plus refresh detection for held operands.
    always_comb begin
        rv_a_p0  = read_value(rd_addr_a, regs[rd_addr_a], wr_en, wr_addr, wr_data);
        rv_b_p0  = read_value(rd_addr_b, regs[rd_addr_b], wr_en, wr_addr, wr_data);
        hit_a_p1 = write_hits(wr_en, wr_addr, addr_a_p1);
        hit_b_p1 = write_hits(wr_en, wr_addr, addr_b_p1);
    end

    // ---- stage p1: ID/EX pipeline register ----
    // ID/EX update with priority reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            addr_a_p1 <= '0;
            addr_b_p1 <= '0;
            data_a_p1 <= '0;
            data_b_p1 <= '0;
        end else if (flush) begin
            vld_p1    <= 1'b0;
            addr_a_p1 <= '0;
            addr_b_p1 <= '0;
            data_a_p1 <= '0;
            data_b_p1 <= '0;
        end else if (stall) begin
            // Held operands pick up a writeback to their source register.
            if (hit_a_p1) begin
                data_a_p1 <= wr_data;
            end
            if (hit_b_p1) begin
                data_b_p1 <= wr_data;
            end
        end else begin
            vld_p1    <= in_valid;
            addr_a_p1 <= rd_addr_a;
            addr_b_p1 <= rd_addr_b;
            data_a_p1 <= rv_a_p0;
            data_b_p1 <= rv_b_p0;
        end
    end

    assign out_valid  = vld_p1;
    assign out_addr_a = addr_a_p1;
    assign out_addr_b = addr_b_p1;
    assign out_data_a = data_a_p1;
    assign out_data_b = data_b_p1;

endmodule
